fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF stage. Owns the PC, issues instruction-bus requests, and drives the F/D pipeline register that feeds decode.
- Consumes stallF/flushF from the hazard unit and the EX branch target.
- Produces ibusy back to the hazard unit so the pipeline front stalls on fetch latency.
- Tolerates arbitrary bus latency and discards responses made stale by a redirect.

Parameters:
RESET_PC, 64'h8000_0000, PC loaded on reset
INSTR_BYTES, 4, PC increment per sequential fetch

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
stallF  in  1  hold PC and F/D register
flushF  in  1  redirect: discard in-flight and held fetches
redirect_pc  in  64  new PC, valid when flushF=1
ireq_valid  out  1  instruction request valid
ireq_addr  out  64  request address (= pc)
iresp_addr_ok  in  1  bus accepted address this cycle
iresp_data_ok  in  1  bus returns data this cycle
iresp_data  in  32  instruction word
f_valid  out  1  F/D register holds a live instruction
f_pc  out  64  F/D pc
f_instr  out  32  F/D instruction
ibusy  out  1  no instruction can be delivered this cycle

Behaviour:
- State register, 4 states, enum in shared package:
  - REQ: request presented.
  - WAIT: address accepted, awaiting data.
  - DROP: stale data pending.
  - HOLD: data buffered under stall.
- Reset (sync, highest priority):
  - pc=RESET_PC, state=REQ.
  - f_valid=0, f_pc=0, f_instr=0, buffer cleared.
  - ireq_valid is 1 in the first cycle after reset.
- ireq_valid=1 only in REQ. ireq_addr=pc. pc[1:0] is always 0; redirect_pc[1:0] is ignored.
- In REQ, the address may change before addr_ok (bus permits retargeting an unaccepted request).
- REQ:
  - addr_ok → WAIT.
  - flushF → pc=redirect_pc, stay REQ (even if addr_ok that cycle → go DROP instead).
- WAIT, on data_ok:
  - !stallF: f_valid=1, f_pc=pc, f_instr=iresp_data, pc+=INSTR_BYTES → REQ. Back-to-back issue; latency from addr_ok to f_valid is bus latency + 1 cycle.
  - stallF: capture {pc, data} into buffer → HOLD. f_* unchanged.
- WAIT, flushF without data_ok → pc=redirect_pc → DROP.
- WAIT, flushF with data_ok → data discarded, pc=redirect_pc → REQ.
- DROP:
  - data_ok → discard data → REQ.
  - flushF → pc=redirect_pc, stay DROP; if data_ok in the same cycle → REQ.
- HOLD:
  - !stallF → f_*=buffer, f_valid=1, pc+=INSTR_BYTES → REQ.
  - flushF → discard buffer, pc=redirect_pc → REQ.
- F/D register:
  - flushF → f_valid=0.
  - Else stallF → hold.
  - Else, if no new instruction is delivered this cycle → f_valid=0 (bubble).
- Priority: reset > flushF > stallF > normal.
- ibusy = (state==REQ) | (state==DROP) | (state==WAIT & !iresp_data_ok). HOLD is not busy.
- pc arithmetic is 64-bit; wrap at 2^64 is unchecked.

Decomposition:
- common package: addr_t (64), instr_t (32), ibus_req_t {valid, addr}, ibus_resp_t {addr_ok, data_ok, data}.
- pipes package: fetch_state_t enum; fetch_data_t {valid, pc, instr} for the F/D register.
- Natural sub-module: pc_reg (pc register with reset/redirect/increment select). The FSM stays in fetch_unit.

Test Plan:
1. Reset, bus with addr_ok immediately and data_ok 1 cycle later, no stall → ireq_addr 8000_0000, 8000_0004, 8000_0008; f_pc tracks with f_instr=iresp_data; f_valid pulses each delivery.
2. stallF=1 on the data_ok cycle for 3 cycles → state HOLD, ibusy=0, f_* unchanged; on release f_pc=8000_0004, then ireq_addr=8000_0008.
3. flushF with redirect_pc=8000_1000 while in WAIT; stale data_ok (0xdeadbeef) arrives 2 cycles later → data dropped, f_valid stays 0, next ireq_addr=8000_1000.
4. flushF with redirect_pc=8000_2002 in the same cycle as addr_ok → DROP entered; next request addr=8000_2000.
5. flushF in HOLD with redirect_pc=8000_3000 → buffer discarded, f_valid=0, next ireq_addr=8000_3000.
6. reset asserted mid-WAIT with a pending response → pc=8000_0000, f_valid=0; next ireq_addr=8000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: bus request/response, fetch FSM states
// and the F/D pipeline register payload.
package fetch_unit_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] instr_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic   addr_ok;
    logic   data_ok;
    instr_t data;
  } ibus_resp_t;

  // DROP: a response already in flight belongs to a redirected-away PC
  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic   valid;
    addr_t  pc;
    instr_t instr;
  } fetch_data_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: reset value, redirect load (word aligned) or
// sequential advance.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter addr_t RESET_PC    = 64'h8000_0000,
  parameter int    INSTR_BYTES = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_redirect,
  input  addr_t i_redirectPc,
  input  logic  i_advance,
  output addr_t o_pc
);

  addr_t r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= {i_redirectPc[63:2], 2'b00};
    end else if (i_advance) begin
      r_pc <= r_pc + addr_t'(INSTR_BYTES);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives the instruction bus, buffers a response that
// lands under stall and feeds the F/D register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t RESET_PC    = 64'h8000_0000,
  parameter int    INSTR_BYTES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stallF,
  input  logic         flushF,
  input  logic [63:0]  redirect_pc,
  output logic         ireq_valid,
  output logic [63:0]  ireq_addr,
  input  logic         iresp_addr_ok,
  input  logic         iresp_data_ok,
  input  logic [31:0]  iresp_data,
  output logic         f_valid,
  output logic [63:0]  f_pc,
  output logic [31:0]  f_instr,
  output logic         ibusy
);

  fetch_state_t r_state;
  fetch_state_t w_nextState;
  fetch_data_t  r_fd;
  addr_t        r_bufPc;
  instr_t       r_bufInstr;
  addr_t        w_pc;
  ibus_req_t    w_req;
  ibus_resp_t   w_resp;
  logic         w_advance;
  logic         w_deliver;
  logic         w_capture;
  addr_t        w_delPc;
  instr_t       w_delInstr;

  assign w_resp = '{addr_ok: iresp_addr_ok, data_ok: iresp_data_ok, data: iresp_data};

  pc_reg #(
    .RESET_PC   (RESET_PC),
    .INSTR_BYTES(INSTR_BYTES)
  ) u_pcReg (
    .clk         (clk),
    .reset       (reset),
    .i_redirect  (flushF),
    .i_redirectPc(redirect_pc),
    .i_advance   (w_advance),
    .o_pc        (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= REQ;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A flush always wins; a redirected in-flight response must still be drained in DROP
  always_comb begin
    w_nextState = r_state;
    w_advance   = 1'b0;
    w_deliver   = 1'b0;
    w_capture   = 1'b0;
    w_delPc     = w_pc;
    w_delInstr  = w_resp.data;
    case (r_state)
      REQ: begin
        if (flushF) begin
          w_nextState = w_resp.addr_ok ? DROP : REQ;
        end else if (w_resp.addr_ok) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (flushF) begin
          w_nextState = w_resp.data_ok ? REQ : DROP;
        end else if (w_resp.data_ok) begin
          if (stallF) begin
            w_capture   = 1'b1;
            w_nextState = HOLD;
          end else begin
            w_deliver   = 1'b1;
            w_advance   = 1'b1;
            w_nextState = REQ;
          end
        end
      end
      DROP: begin
        if (w_resp.data_ok) begin
          w_nextState = REQ;
        end
      end
      HOLD: begin
        if (flushF) begin
          w_nextState = REQ;
        end else if (!stallF) begin
          w_deliver   = 1'b1;
          w_delPc     = r_bufPc;
          w_delInstr  = r_bufInstr;
          w_advance   = 1'b1;
          w_nextState = REQ;
        end
      end
      default: w_nextState = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fd       <= '0;
      r_bufPc    <= '0;
      r_bufInstr <= '0;
    end else begin
      if (w_capture) begin
        r_bufPc    <= w_pc;
        r_bufInstr <= w_resp.data;
      end
      if (flushF) begin
        r_fd.valid <= 1'b0;
      end else if (!stallF) begin
        if (w_deliver) begin
          r_fd <= '{valid: 1'b1, pc: w_delPc, instr: w_delInstr};
        end else begin
          r_fd.valid <= 1'b0;
        end
      end
    end
  end

  assign w_req      = '{valid: (r_state == REQ), addr: w_pc};
  assign ireq_valid = w_req.valid;
  assign ireq_addr  = w_req.addr;
  assign f_valid    = r_fd.valid;
  assign f_pc       = r_fd.pc;
  assign f_instr    = r_fd.instr;
  assign ibusy      = (r_state == REQ) || (r_state == DROP) ||
                      ((r_state == WAIT) && !w_resp.data_ok);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model (outstanding request
// queue, held instruction, F/D register) is compared against the DUT every cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stallF = 1'b0;
  logic        flushF = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        ibusy;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stallF       (stallF),
    .flushF       (flushF),
    .redirect_pc  (redirect_pc),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .f_valid      (f_valid),
    .f_pc         (f_pc),
    .f_instr      (f_instr),
    .ibusy        (ibusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    bit          stale;
  } outEntry_t;

  outEntry_t   mOut[$];
  bit          mReady = 0;
  logic [63:0] mPc = '0;
  bit          mHeld = 0;
  logic [63:0] mHeldPc = '0;
  logic [31:0] mHeldInstr = '0;
  bit          mFValid = 0;
  logic [63:0] mFPc = '0;
  logic [31:0] mFInstr = '0;

  // Model: one request may be outstanding; a redirect marks it stale so its data is dropped
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mOut.delete();
        mReady = 1;
        mPc = 64'h8000_0000;
        mHeld = 0;
        mFValid = 0;
        mFPc = '0;
        mFInstr = '0;
      end else begin
        bit          deliver;
        logic [63:0] dPc;
        logic [31:0] dInstr;
        outEntry_t   e;
        deliver = 0;
        dPc = '0;
        dInstr = '0;
        if (mOut.size() != 0) begin
          if (iresp_data_ok) begin
            e = mOut.pop_front();
            if (!e.stale && !flushF) begin
              if (stallF) begin
                mHeld = 1;
                mHeldPc = e.pc;
                mHeldInstr = iresp_data;
              end else begin
                deliver = 1;
                dPc = e.pc;
                dInstr = iresp_data;
                mPc = e.pc + 64'd4;
              end
            end
          end else if (flushF) begin
            e = mOut[0];
            e.stale = 1;
            mOut[0] = e;
          end
        end else if (mHeld) begin
          if (flushF) begin
            mHeld = 0;
          end else if (!stallF) begin
            deliver = 1;
            dPc = mHeldPc;
            dInstr = mHeldInstr;
            mPc = mHeldPc + 64'd4;
            mHeld = 0;
          end
        end else if (iresp_addr_ok) begin
          mOut.push_back('{pc: mPc, stale: flushF});
        end
        if (flushF) mPc = redirect_pc & ~64'd3;
        if (flushF) begin
          mFValid = 0;
        end else if (!stallF) begin
          if (deliver) begin
            mFValid = 1;
            mFPc = dPc;
            mFInstr = dInstr;
          end else begin
            mFValid = 0;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mReady) begin
        bit issuing;
        bit busy;
        issuing = (mOut.size() == 0) && !mHeld;
        busy = issuing || ((mOut.size() != 0) && (mOut[0].stale || !iresp_data_ok));
        checkOutput("ireq_valid", 64'(ireq_valid), 64'(issuing));
        checkOutput("ireq_addr", ireq_addr, mPc);
        checkOutput("ibusy", 64'(ibusy), 64'(busy));
        checkOutput("f_valid", 64'(f_valid), 64'(mFValid));
        checkOutput("f_pc", f_pc, mFPc);
        checkOutput("f_instr", 64'(f_instr), 64'(mFInstr));
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic st, input logic fl,
                               input logic [63:0] rpc, input logic aok, input logic dok,
                               input logic [31:0] dat);
    @(posedge clk);
    #1;
    reset = rst;
    stallF = st;
    flushF = fl;
    redirect_pc = rpc;
    iresp_addr_ok = aok;
    iresp_data_ok = dok;
    iresp_data = dat;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rst_ireq_valid", 64'(ireq_valid), 64'd1);
    checkOutput("rst_ireq_addr", ireq_addr, 64'h8000_0000);
    checkOutput("rst_f_valid", 64'(f_valid), 64'd0);
    checkOutput("rst_f_pc", f_pc, 64'd0);
    checkOutput("rst_ibusy", 64'(ibusy), 64'd1);

    // Sequential fetch, one-cycle data latency
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1111_0000);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    #1;
    checkOutput("seq0_f_valid", 64'(f_valid), 64'd1);
    checkOutput("seq0_f_pc", f_pc, 64'h8000_0000);
    checkOutput("seq0_f_instr", 64'(f_instr), 64'h1111_0000);
    checkOutput("seq1_ireq_addr", ireq_addr, 64'h8000_0004);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1111_0001);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    #1;
    checkOutput("seq1_f_pc", f_pc, 64'h8000_0004);
    checkOutput("seq2_ireq_addr", ireq_addr, 64'h8000_0008);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1111_0002);

    // Stall: issue under stall, data lands stalled, held for three cycles
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    #1;
    checkOutput("seq2_f_pc", f_pc, 64'h8000_0008);
    checkOutput("seq3_ireq_addr", ireq_addr, 64'h8000_000C);
    applyStimulus(0, 1, 0, 0, 0, 1, 32'h2222_0000);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("hold_ibusy", 64'(ibusy), 64'd0);
    checkOutput("hold_ireq_valid", 64'(ireq_valid), 64'd0);
    checkOutput("hold_f_valid", 64'(f_valid), 64'd1);
    checkOutput("hold_f_pc", f_pc, 64'h8000_0008);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    #1;
    checkOutput("release_f_valid", 64'(f_valid), 64'd1);
    checkOutput("release_f_pc", f_pc, 64'h8000_000C);
    checkOutput("release_f_instr", 64'(f_instr), 64'h2222_0000);
    checkOutput("release_ireq_addr", ireq_addr, 64'h8000_0010);

    // Flush while waiting; stale data two cycles later is dropped
    applyStimulus(0, 0, 1, 64'h8000_1000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("drop_ibusy", 64'(ibusy), 64'd1);
    checkOutput("drop_ireq_valid", 64'(ireq_valid), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("stale_f_valid", 64'(f_valid), 64'd0);
    checkOutput("redir1_ireq_addr", ireq_addr, 64'h8000_1000);
    checkOutput("redir1_ireq_valid", 64'(ireq_valid), 64'd1);

    // Flush coincident with addr_ok; misaligned redirect is aligned
    applyStimulus(0, 0, 1, 64'h8000_2002, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("drop2_ireq_valid", 64'(ireq_valid), 64'd0);
    checkOutput("drop2_ireq_addr", ireq_addr, 64'h8000_2000);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h3333_0000);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    #1;
    checkOutput("redir2_ireq_valid", 64'(ireq_valid), 64'd1);
    checkOutput("redir2_f_valid", 64'(f_valid), 64'd0);

    // Flush while holding a buffered instruction
    applyStimulus(0, 1, 0, 0, 0, 1, 32'h4444_0000);
    applyStimulus(0, 1, 1, 64'h8000_3000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("holdflush_f_valid", 64'(f_valid), 64'd0);
    checkOutput("holdflush_ireq_addr", ireq_addr, 64'h8000_3000);
    checkOutput("holdflush_ireq_valid", 64'(ireq_valid), 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h5555_0000);
    applyStimulus(0, 0, 1, 64'h8000_4008, 0, 0, 0);
    #1;
    checkOutput("after_hold_f_pc", f_pc, 64'h8000_3000);
    checkOutput("after_hold_f_instr", 64'(f_instr), 64'h5555_0000);

    // Retarget an unaccepted request, then flush coincident with data_ok
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    #1;
    checkOutput("retarget_ireq_addr", ireq_addr, 64'h8000_4008);
    applyStimulus(0, 0, 1, 64'h8000_5000, 0, 1, 32'h6666_0000);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    #1;
    checkOutput("flushdata_ireq_addr", ireq_addr, 64'h8000_5000);
    checkOutput("flushdata_f_valid", 64'(f_valid), 64'd0);

    // Reset mid-WAIT with a response arriving afterwards
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h8888_0000);
    #1;
    checkOutput("midrst_f_valid", 64'(f_valid), 64'd0);
    checkOutput("midrst_f_instr", 64'(f_instr), 64'd0);
    checkOutput("midrst_ireq_addr", ireq_addr, 64'h8000_0000);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h9999_0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("postrst_f_pc", f_pc, 64'h8000_0000);
    checkOutput("postrst_f_instr", 64'(f_instr), 64'h9999_0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
